// File: rtl/mef_fertirrig_multi.sv
// mef_fertirrig_multi: multi-sector fertigation sequencer.
//
// Arbitrates per-sector irrigation requests round-robin. It fills the shared
// tank, optionally runs the fertiliser mixer, drives the selected sector valve,
// and flushes the line after fertiliser runs. FILL is timed out, and an
// inconsistent level-sensor pair (high set, low clear) forces a latched FAULT.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   Adub   - fertiliser mode request, latched when a run starts
//   Nv1    - tank high-level sensor (1 = full)
//   Nv0    - tank low-level sensor (1 = water above low mark)
//   Asp    - per-sector irrigation requests
//   Ve     - tank fill / fresh-water valve
//   Mist   - fertiliser mixer
//   Limp   - line cleaning (flush)
//   Sect   - one-hot sector valve, or all-zero
//   Busy   - a run is in progress (not IDLE, not FAULT)
//   Fault  - FAULT state, left only through reset
module mef_fertirrig_multi #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned MIX_CYC   = 16,
  parameter int unsigned CLEAN_CYC = 32,
  parameter int unsigned FILL_TO   = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           Adub,
  input  logic           Nv1,
  input  logic           Nv0,
  input  logic [NCH-1:0] Asp,
  output logic           Ve,
  output logic           Mist,
  output logic           Limp,
  output logic [NCH-1:0] Sect,
  output logic           Busy,
  output logic           Fault
);

  localparam int unsigned MaxMc  = (MIX_CYC > CLEAN_CYC) ? MIX_CYC : CLEAN_CYC;
  localparam int unsigned MaxCyc = (MaxMc > FILL_TO) ? MaxMc : FILL_TO;
  localparam int unsigned CW     = $clog2(MaxCyc + 1);
  localparam int unsigned ChW    = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StMix,
    StIrrig,
    StClean,
    StFault
  } state_e;

  state_e         state_q, state_d;
  logic [ChW-1:0] ch_q, ch_d;
  logic [ChW-1:0] last_q, last_d;
  logic           fert_q, fert_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [ChW-1:0] pick;
  logic           any_req;
  logic           sensor_fault;

  // Round-robin pick: first requester strictly after the last served sector.
  always_comb begin
    int unsigned idx;
    pick    = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = (int'(last_q) + i) % NCH;
      if (!any_req && Asp[ChW'(idx)]) begin
        any_req = 1'b1;
        pick    = ChW'(idx);
      end
    end
  end

  // Full-without-low is physically impossible: one sensor is broken.
  assign sensor_fault = Nv1 && !Nv0 && (state_q != StFault);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    last_d  = last_q;
    fert_d  = fert_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          ch_d    = pick;
          fert_d  = Adub;
          state_d = Nv1 ? (Adub ? StMix : StIrrig) : StFill;
        end
      end
      StFill: begin
        if (Nv1) begin
          state_d = fert_q ? StMix : StIrrig;
        end else if (cnt_q == CW'(FILL_TO - 1)) begin
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StMix: begin
        if (cnt_q == CW'(MIX_CYC - 1)) begin
          state_d = StIrrig;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StIrrig: begin
        if (!Asp[ch_q]) begin
          state_d = fert_q ? StClean : StIdle;
          last_d  = ch_q;
        end else if (!Nv0) begin
          // Plain runs refill and resume the same sector; fert runs flush.
          state_d = fert_q ? StClean : StFill;
        end
      end
      StClean: begin
        if (cnt_q == CW'(CLEAN_CYC - 1)) begin
          state_d = StIdle;
          last_d  = ch_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StFault: ;
      default: state_d = StFault;
    endcase

    if (sensor_fault) begin
      state_d = StFault;
      ch_d    = ch_q;
      last_d  = last_q;
      fert_d  = fert_q;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ch_q    <= '0;
      last_q  <= ChW'(NCH - 1);
      fert_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      fert_q  <= fert_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore outputs, decoded from registered state only.
  always_comb begin
    Ve    = 1'b0;
    Mist  = 1'b0;
    Limp  = 1'b0;
    Sect  = '0;
    Busy  = 1'b0;
    Fault = 1'b0;
    unique case (state_q)
      StIdle: ;
      StFill: begin
        Ve   = 1'b1;
        Busy = 1'b1;
      end
      StMix: begin
        Mist = 1'b1;
        Busy = 1'b1;
      end
      StIrrig: begin
        Sect[ch_q] = 1'b1;
        Busy       = 1'b1;
      end
      StClean: begin
        Ve         = 1'b1;
        Limp       = 1'b1;
        Sect[ch_q] = 1'b1;
        Busy       = 1'b1;
      end
      StFault: Fault = 1'b1;
      default: Fault = 1'b1;
    endcase
  end

endmodule

// File: doc/mef_fertirrig_multi.md
# mef_fertirrig_multi

Multi-sector fertigation sequencer for the irrigation controller. It arbitrates sprinkler requests from `NCH` sectors round-robin and fills the shared tank. It optionally mixes fertiliser, drives the selected sector valve, and flushes the line after fertiliser runs. Mix and clean phases are timed, fill has a timeout, and sensor faults are detected. It sits between the sector request inputs (one per sprinkler line) and the valve/mixer/cleaning actuators.

## Interface
- `NCH`, 4: number of sectors (≥2).
- `MIX_CYC`, 16: cycles the mixer runs before irrigation in fertiliser mode (≥1).
- `CLEAN_CYC`, 32: cycles of line flush after a fertiliser run (≥1).
- `FILL_TO`, 255: maximum FILL cycles before fault (≥1).
- `CW`, derived: counter width = clog2(max(MIX_CYC, CLEAN_CYC, FILL_TO)+1).

Ports (clock and reset first):
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `Adub` in 1: fertiliser mode request; sampled only when a run starts.
- `Nv1` in 1: tank high-level sensor (1 = full).
- `Nv0` in 1: tank low-level sensor (1 = water above low mark).
- `Asp` in NCH: per-sector irrigation request.
- `Ve` out 1: tank fill / fresh-water valve.
- `Mist` out 1: fertiliser mixer.
- `Limp` out 1: line cleaning (flush).
- `Sect` out NCH: one-hot sector valve, or all-zero.
- `Busy` out 1: state ≠ IDLE and ≠ FAULT.
- `Fault` out 1: in FAULT state.

## Operation
- Registers: `state` (IDLE, FILL, MIX, IRRIG, CLEAN, FAULT); `ch` (served sector); `last` (last served sector, reset NCH-1); `fert` (latched mode); `cnt` (CW bits, cleared on every state change).
- Outputs decode registered state only (Moore):
  - IDLE: all outputs 0.
  - FILL: `Ve`=1.
  - MIX: `Mist`=1.
  - IRRIG: `Sect[ch]`=1.
  - CLEAN: `Ve`=1, `Limp`=1, `Sect[ch]`=1.
  - FAULT: `Fault`=1, all actuators 0.
- Sensor fault: `Nv1`=1 with `Nv0`=0 in any non-FAULT state → FAULT at the next edge. This has priority over all other transitions.
- IDLE:
  - If any `Asp` bit is set: `ch` ← first requesting index searching from `last`+1, wrapping at NCH; `fert` ← `Adub`.
  - Next state: `Nv1`=1 → (`fert`? MIX : IRRIG); otherwise → FILL.
- FILL:
  - `Nv1`=1 → (fert? MIX : IRRIG).
  - Else `cnt`==FILL_TO−1 → FAULT.
  - Else `cnt`++.
- MIX: `cnt`==MIX_CYC−1 → IRRIG; else `cnt`++.
- IRRIG, in priority order:
  1. `Asp[ch]`=0 → (fert? CLEAN : IDLE); `last` ← `ch`.
  2. `Nv0`=0 → (fert? CLEAN : FILL). In plain mode the same `ch` resumes after refill; fert runs are not refilled mid-run.
  3. Otherwise stay in IRRIG.
- CLEAN: `cnt`==CLEAN_CYC−1 → IDLE, `last` ← `ch`; else `cnt`++. CLEAN completes even if `Asp[ch]` drops or rises.
- FAULT: exit only via `reset`.
- `Asp` changes on other sectors never pre-empt the current run.
- `Adub` changes after run start are ignored.

## Timing
- Reset: state IDLE, `ch`=0, `last`=NCH−1, `fert`=0, `cnt`=0. All outputs 0. Asynchronous assert, synchronous-edge release.
- Request-to-actuator latency is 1 cycle: `Asp` sampled high at edge k gives `Ve`, `Mist` or `Sect` high from edge k.
- MIX has `Mist` high for exactly MIX_CYC cycles. CLEAN has `Limp` high for exactly CLEAN_CYC cycles.
- FILL lasts at most FILL_TO cycles, then FAULT.
- `Sect` is always one-hot or zero. `Mist` and `Limp` are never both 1.
- Two or more simultaneous requests: the lowest index at or after `last`+1 is served; the others are served in later runs.
- Reset asserted mid-run forces all actuators off immediately, without waiting for a clock edge.

## Test plan
All scenarios use NCH=4, MIX_CYC=4, CLEAN_CYC=3, FILL_TO=8.

- Plain run: `Nv1`=`Nv0`=1, `Adub`=0, `Asp`=0010 for 5 cycles then 0000 → `Sect`=0010 for 5 cycles, then IDLE; `Ve`, `Mist`, `Limp` stay 0.
- Fert run from empty tank: `Nv1`=0, `Nv0`=1, `Adub`=1, `Asp`=0001; `Nv1`→1 after 3 cycles; drop `Asp` after 6 IRRIG cycles → `Ve` high 3 cycles, `Mist` 4, `Sect`=0001 6, then `Limp`+`Ve`+`Sect`=0001 for 3 cycles, then IDLE.
- Round-robin: `Asp`=1011 held, each run ended by toggling the served bit → service order 0, 1, 3, 0 (reset `last`=3).
- Fill timeout: `Nv1`=0, `Nv0`=1, `Asp`=0100 → `Ve` high 8 cycles, then `Fault`=1 with all actuators 0 until `reset`=0.
- Sensor fault: during IRRIG drive `Nv1`=1, `Nv0`=0 → next edge `Fault`=1, `Sect`=0000.
- Mid-run reset: pull `reset` low during MIX → `Mist`=0 without a clock edge; after release, outputs stay 0 and `Busy`=0 until a new request.
